// File: rtl/comparador_serial_izqder_pkg.sv
// Shared definitions for the serial MSB-first magnitude comparator.
//   ST_IDLE / ST_RUN / ST_DONE : controller states
//   ST_BAD                     : unused encoding, always steered back to ST_IDLE
//   DEF_GRP                    : default group width (one 3-bit cell per cycle)
//   idxWidth()                 : width of the group index counter, never below 1
package comparador_serial_izqder_pkg;

  localparam int DEF_GRP = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_BAD  = 2'd3
  } state_t;

  // A single group still needs a 1-bit counter so the index mux has a select.
  function automatic int idxWidth(input int ngrp);
    return (ngrp > 1) ? $clog2(ngrp) : 1;
  endfunction

endpackage

// File: rtl/comparador_serial_izqder_celda_grupo.sv
// Combinational group cell (celda_grupo) of the left-to-right comparator.
// Once an earlier (more significant) group has decided, the f/g pair passes
// through untouched; otherwise this group decides.
//   i_a, i_b : GRP-bit groups of A and B at the same position
//   i_f, i_g : incoming carry, f = A>B so far, g = A<B so far
//   o_f, o_g : outgoing carry
module comparador_serial_izqder_celda_grupo
  import comparador_serial_izqder_pkg::*;
#(
  parameter int GRP = DEF_GRP
) (
  input  logic [GRP-1:0] i_a,
  input  logic [GRP-1:0] i_b,
  input  logic           i_f,
  input  logic           i_g,
  output logic           o_f,
  output logic           o_g
);

  logic w_decided;

  assign w_decided = i_f | i_g;
  assign o_f       = w_decided ? i_f : (i_a > i_b);
  assign o_g       = w_decided ? i_g : (i_a < i_b);

endmodule

// File: rtl/comparador_serial_izqder.sv
// Sequential MSB-first magnitude comparator for WIDTH-bit unsigned operands.
// One GRP-bit group is compared per clock through a single shared cell, and
// the scan stops at the first group that differs.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (accepts only in IDLE)
//   A, B                 : operands, captured on the accept edge
//   out_valid / out_ready: result handshake (result held while stalled)
//   gt, lt, eq           : A>B, A<B, A==B
module comparador_serial_izqder
  import comparador_serial_izqder_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int GRP   = DEF_GRP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int NGRP = WIDTH / GRP;
  localparam int IDXW = idxWidth(NGRP);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NGRP - 1);

  // Operands must split into whole groups; anything else is a configuration error.
  if ((GRP < 1) || (WIDTH < GRP) || ((WIDTH % GRP) != 0)) begin : g_badWidth
    $error("comparador_serial_izqder: WIDTH must be a non-zero multiple of GRP");
  end

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [IDXW-1:0]  r_idx;
  logic             r_f;
  logic             r_g;
  logic [GRP-1:0]   w_a;
  logic [GRP-1:0]   w_b;
  logic             w_f;
  logic             w_g;
  logic             w_accept;
  logic             w_runEnd;

  // The group currently under scan, most significant first.
  assign w_a = r_opA[r_idx*GRP +: GRP];
  assign w_b = r_opB[r_idx*GRP +: GRP];

  comparador_serial_izqder_celda_grupo #(
    .GRP (GRP)
  ) u_celda (
    .i_a (w_a),
    .i_b (w_b),
    .i_f (r_f),
    .i_g (r_g),
    .o_f (w_f),
    .o_g (w_g)
  );

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign w_accept  = in_valid & in_ready;
  // Stop as soon as a group differs, or after the least significant group.
  assign w_runEnd  = w_f | w_g | (r_idx == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic; the spare encoding falls back to IDLE.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_stateNext = ST_RUN;
      ST_RUN:  if (w_runEnd)  w_stateNext = ST_DONE;
      ST_DONE: if (out_ready) w_stateNext = ST_IDLE;
      default:                w_stateNext = ST_IDLE;
    endcase
  end

  // Datapath: operands are captured once, then f/g and the index evolve
  // during RUN only. f/g keep the result after hand-off until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opA <= '0;
      r_opB <= '0;
      r_idx <= '0;
      r_f   <= 1'b0;
      r_g   <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_accept) begin
      r_opA <= A;
      r_opB <= B;
      r_idx <= IDX_LAST;
      r_f   <= 1'b0;
      r_g   <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_f <= w_f;
      r_g <= w_g;
      if (!w_runEnd) begin
        r_idx <= r_idx - 1'b1;
      end
    end
  end

  assign gt = r_f;
  assign lt = r_g;
  assign eq = ~r_f & ~r_g;

endmodule

// File: tb/tb_comparador_serial_izqder.sv
// Directed bench for comparador_serial_izqder (WIDTH=12, GRP=3, octal groups),
// followed by a randomised back-to-back run checked against a behavioural model.
module tb_comparador_serial_izqder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] A;
  logic [11:0] B;
  logic        out_valid;
  logic        out_ready;
  logic        gt;
  logic        lt;
  logic        eq;

  int testCount = 0;
  int failCount = 0;

  comparador_serial_izqder #(
    .WIDTH (12),
    .GRP   (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gt        (gt),
    .lt        (lt),
    .eq        (eq)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Reference latency: one edge plus one per equal leading group, capped at 4.
  function automatic int refLatency(input logic [11:0] a, input logic [11:0] b);
    int n;
    n = 1;
    for (int g = 3; g >= 1; g--) begin
      if (a[g*3 +: 3] == b[g*3 +: 3]) n++;
      else break;
    end
    return n;
  endfunction

  // Runs one full operation: offer operands, scramble inputs after accept,
  // measure latency, check result, optionally stall with ignored in_valid
  // pulses, then hand off and confirm the return to IDLE.
  task automatic applyStimulus(input logic [11:0] a, input logic [11:0] b,
                               input logic expGt, input logic expLt,
                               input int expLat, input int stall, input bit pulse);
    int  lat;
    bit  seen;
    @(negedge clk);
    A        = a;
    B        = b;
    in_valid = 1'b1;
    checkOutput("inReadyBeforeAccept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A        = ~a;
    B        = a;
    checkOutput("noValidOnAcceptEdge", out_valid, 0);
    lat  = 0;
    seen = 1'b0;
    for (int e = 1; e <= 10 && !seen; e++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        seen = 1'b1;
        lat  = e;
      end
    end
    checkOutput("latency", lat, expLat);
    checkOutput("gt", gt, expGt);
    checkOutput("lt", lt, expLt);
    checkOutput("eq", eq, !expGt && !expLt);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (pulse) begin
        in_valid = 1'b1;
        A        = 12'o0001;
        B        = 12'o7000;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("stallValid", out_valid, 1);
      checkOutput("stallInReady", in_ready, 0);
      checkOutput("stallGt", gt, expGt);
      checkOutput("stallLt", lt, expLt);
      checkOutput("stallEq", eq, !expGt && !expLt);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("handoffValidLow", out_valid, 0);
    checkOutput("handoffInReady", in_ready, 1);
  endtask

  // Main sequence.
  initial begin
    logic [11:0] ra;
    logic [11:0] rb;
    logic [11:0] mask;
    int          k;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;

    // Reset values while rst_n is held low.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstInReady", in_ready, 1);
    checkOutput("rstOutValid", out_valid, 0);
    checkOutput("rstGt", gt, 0);
    checkOutput("rstLt", lt, 0);
    checkOutput("rstEq", eq, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Hand-computed directed vectors.
    applyStimulus(12'o5000, 12'o4777, 1'b1, 1'b0, 1, 0, 1'b0);
    applyStimulus(12'o1234, 12'o1235, 1'b0, 1'b1, 4, 0, 1'b0);
    applyStimulus(12'o7777, 12'o7777, 1'b0, 1'b0, 4, 0, 1'b0);
    applyStimulus(12'o0000, 12'o0000, 1'b0, 1'b0, 4, 0, 1'b0);
    applyStimulus(12'o3300, 12'o3400, 1'b0, 1'b1, 2, 0, 1'b0);
    applyStimulus(12'o7650, 12'o7640, 1'b1, 1'b0, 3, 0, 1'b0);
    applyStimulus(12'o0007, 12'o0006, 1'b1, 1'b0, 4, 0, 1'b0);

    // Backpressure: five stalled cycles with in_valid pulses that must be ignored.
    applyStimulus(12'o6000, 12'o2777, 1'b1, 1'b0, 1, 5, 1'b1);
    applyStimulus(12'o4443, 12'o4445, 1'b0, 1'b1, 4, 5, 1'b1);

    // Reset asserted in the second cycle of an operation aborts it at once.
    @(negedge clk);
    A        = 12'o1110;
    B        = 12'o1111;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstInReady", in_ready, 1);
    checkOutput("midRstOutValid", out_valid, 0);
    checkOutput("midRstGt", gt, 0);
    checkOutput("midRstLt", lt, 0);
    checkOutput("midRstEq", eq, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("postRstOutValid", out_valid, 0);
    applyStimulus(12'o1110, 12'o1111, 1'b0, 1'b1, 4, 0, 1'b0);

    // Random back-to-back operations with random idle gaps and stalls;
    // B shares a random number of leading groups with A to spread latency.
    for (int i = 0; i < 2000; i++) begin
      ra   = 12'($urandom);
      k    = $urandom_range(0, 4);
      mask = 12'((32'd1 << (k * 3)) - 1);
      rb   = ra ^ (12'($urandom) & mask);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(ra, rb, ra > rb, ra < rb, refLatency(ra, rb),
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
